// File: rtl/acc_frame_ctrl_pkg.sv
// acc_frame_ctrl_pkg: shared state encoding and datapath widths for the accumulator frame sequencer
package acc_frame_ctrl_pkg;
   localparam int ACC_IN_W  = 16;
   localparam int ACC_OUT_W = 17;
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_RESULT,
      ST_CLEAR
   } state_e;
endpackage

// File: rtl/acc_frame_ctrl.sv
// acc_frame_ctrl: frame sequencer streaming samples into a signed accumulator and returning the frame sum
// Ports: CLK/NRST clock and async active-low reset; START/CFG_LEN frame request (IDLE only);
//        ABORT abandons the frame in flight; S_VALID/S_DATA/S_READY sample input handshake;
//        M_VALID/M_DATA/M_READY result handshake; BUSY high outside IDLE;
//        ACC_IN/ACC_EN2/ACC_EN3/ACC_NRST drive the accumulator, ACC_OUT is its sum register.
module acc_frame_ctrl
   import acc_frame_ctrl_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic                 CLK,
   input  logic                 NRST,
   input  logic                 START,
   input  logic [LEN_W-1:0]     CFG_LEN,
   input  logic                 ABORT,
   input  logic                 S_VALID,
   input  logic [ACC_IN_W-1:0]  S_DATA,
   output logic                 S_READY,
   output logic                 M_VALID,
   output logic [ACC_OUT_W-1:0] M_DATA,
   input  logic                 M_READY,
   output logic                 BUSY,
   output logic [ACC_IN_W-1:0]  ACC_IN,
   output logic                 ACC_EN2,
   output logic                 ACC_EN3,
   output logic                 ACC_NRST,
   input  logic [ACC_OUT_W-1:0] ACC_OUT
);
   state_e           state_q, state_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             clr_n_q, clr_n_d;
   logic             last;
   // len_q is never zero in ACCUM, so len_q-1 cannot underflow where it matters
   assign last     = count_q == len_q - 1'b1;
   assign ACC_IN   = S_DATA;
   assign M_DATA   = ACC_OUT;
   assign BUSY     = state_q != ST_IDLE;
   // Clear pulse is a plain AND of the reset pin and a flop, so it cannot glitch
   assign ACC_NRST = NRST & clr_n_q;
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      len_d   = len_q;
      clr_n_d = 1'b1;
      S_READY = 1'b0;
      M_VALID = 1'b0;
      ACC_EN2 = 1'b0;
      ACC_EN3 = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               len_d   = CFG_LEN;
               count_d = '0;
               // A zero-length frame reports the already-cleared accumulator
               state_d = (CFG_LEN == '0) ? ST_RESULT : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (ABORT) begin
               state_d = ST_CLEAR;
               clr_n_d = 1'b0;
            end else begin
               S_READY = 1'b1;
               if (S_VALID) begin
                  ACC_EN2 = 1'b1;
                  ACC_EN3 = last;
                  count_d = count_q + 1'b1;
                  state_d = last ? ST_RESULT : ST_ACCUM;
               end
            end
         end
         ST_RESULT: begin
            if (ABORT) begin
               state_d = ST_CLEAR;
               clr_n_d = 1'b0;
            end else begin
               M_VALID = 1'b1;
               if (M_READY) begin
                  state_d = ST_CLEAR;
                  clr_n_d = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         len_q   <= '0;
         clr_n_q <= 1'b1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         len_q   <= len_d;
         clr_n_q <= clr_n_d;
      end
   end
endmodule

// File: tb/tb_acc_frame_ctrl.sv
// tb_acc_frame_ctrl: table-driven, hand-written and randomized checks of acc_frame_ctrl with an accumulator model
module tb_acc_frame_ctrl;
   logic        clk = 1'b0;
   logic        nrst;
   logic        start;
   logic [7:0]  cfg_len;
   logic        abort;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_ready;
   logic        m_valid;
   logic [16:0] m_data;
   logic        m_ready;
   logic        busy;
   logic [15:0] acc_in;
   logic        acc_en2;
   logic        acc_en3;
   logic        acc_nrst;
   logic [16:0] acc_out;
   logic [16:0] acc_ff;
   logic [15:0] samp [256];
   int          n_vec = 0;
   int          n_err = 0;

   typedef struct {
      int          len;
      logic [15:0] base;
      logic [15:0] step;
      int          gap;
      int          stall;
      logic [16:0] exp;
   } vec_t;
   vec_t vecs [8];

   always #5 clk = ~clk;

   acc_frame_ctrl #(.LEN_W(8)) dut (
      .CLK(clk), .NRST(nrst), .START(start), .CFG_LEN(cfg_len), .ABORT(abort),
      .S_VALID(s_valid), .S_DATA(s_data), .S_READY(s_ready),
      .M_VALID(m_valid), .M_DATA(m_data), .M_READY(m_ready), .BUSY(busy),
      .ACC_IN(acc_in), .ACC_EN2(acc_en2), .ACC_EN3(acc_en3), .ACC_NRST(acc_nrst),
      .ACC_OUT(acc_out)
   );

   // Accumulator: EN2 adds IN into the running sum, EN3 loads OUT with sum+IN
   always_ff @(posedge clk or negedge acc_nrst) begin
      if (!acc_nrst) begin
         acc_ff  <= '0;
         acc_out <= '0;
      end else begin
         if (acc_en2) acc_ff <= acc_ff + {acc_in[15], acc_in};
         if (acc_en3) acc_out <= acc_ff + {acc_in[15], acc_in};
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time %0t, required < 300000", $time);
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int len, input logic [15:0] base, input logic [15:0] step);
      for (int i = 0; i < len; i++) samp[i] = 16'(base + 16'(i) * step);
   endtask

   function automatic logic [16:0] ref_sum(input int len);
      logic signed [16:0] s = '0;
      for (int i = 0; i < len; i++) s = s + 17'(signed'(samp[i]));
      return s;
   endfunction

   task automatic run_frame(input int len, input int gap, input int stall, input logic [16:0] exp);
      start   = 1'b1;
      cfg_len = len[7:0];
      tick();
      start = 1'b0;
      for (int i = 0; i < len;) begin
         s_valid = $urandom_range(99) >= gap;
         s_data  = samp[i];
         #1;
         check("s_ready", s_ready, 1);
         check("acc_in", acc_in, s_data);
         check("en2", acc_en2, s_valid);
         check("en3", acc_en3, s_valid && i == len - 1);
         if (s_valid) i++;
         tick();
      end
      s_valid = 1'b0;
      for (int c = 0; c <= stall; c++) begin
         m_ready = c == stall;
         start   = c == 2;
         cfg_len = 8'd7;
         #1;
         check("m_valid", m_valid, 1);
         check("m_data", m_data, exp);
         check("s_ready_res", s_ready, 0);
         tick();
      end
      m_ready = 1'b0;
      start   = 1'b0;
      #1;
      check("clr_nrst_low", acc_nrst, 0);
      check("clr_m_valid", m_valid, 0);
      check("clr_busy", busy, 1);
      tick();
      check("idle_nrst_high", acc_nrst, 1);
      check("idle_busy", busy, 0);
      check("idle_acc_out", acc_out, 0);
   endtask

   initial begin
      nrst = 1'b0; start = 1'b0; cfg_len = '0; abort = 1'b0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      vecs[0] = '{4,   16'h0001, 16'h0001, 0,  0, 17'd10};
      vecs[1] = '{3,   16'hFFFF, 16'h0000, 0,  0, 17'h1FFFD};
      vecs[2] = '{3,   16'h7FFF, 16'h0000, 0,  1, 17'h17FFD};
      vecs[3] = '{2,   16'h0003, 16'h0004, 0,  5, 17'd10};
      vecs[4] = '{0,   16'h0000, 16'h0000, 0,  0, 17'd0};
      vecs[5] = '{255, 16'h0001, 16'h0000, 20, 0, 17'd255};
      vecs[6] = '{2,   16'h8000, 16'h0000, 40, 2, 17'h10000};
      vecs[7] = '{255, 16'hFFFF, 16'h0000, 0,  3, 17'h1FF01};
      #12;
      check("rst_busy", busy, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_en2", acc_en2, 0);
      check("rst_en3", acc_en3, 0);
      check("rst_acc_nrst", acc_nrst, 0);
      check("rst_m_data", m_data, 0);
      nrst = 1'b1;
      tick();
      check("post_rst_acc_nrst", acc_nrst, 1);
      for (int v = 0; v < 8; v++) begin
         fill(vecs[v].len, vecs[v].base, vecs[v].step);
         run_frame(vecs[v].len, vecs[v].gap, vecs[v].stall, vecs[v].exp);
      end
      // ABORT in IDLE does nothing
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle_busy", busy, 0);
      check("abort_idle_nrst", acc_nrst, 1);
      // ABORT in ACCUM after two transfers, with a competing sample, then START during CLEAR
      fill(5, 16'd100, 16'd1);
      start = 1'b1; cfg_len = 8'd5;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_valid = 1'b1; s_data = samp[i];
         tick();
      end
      abort = 1'b1;
      #1;
      check("abort_s_ready", s_ready, 0);
      check("abort_en2", acc_en2, 0);
      check("abort_en3", acc_en3, 0);
      check("abort_m_valid", m_valid, 0);
      tick();
      abort = 1'b0; s_valid = 1'b0; start = 1'b1; cfg_len = 8'd3;
      #1;
      check("abort_clr_nrst", acc_nrst, 0);
      check("abort_clr_m_valid", m_valid, 0);
      tick();
      start = 1'b0;
      check("start_in_clear_ignored", busy, 0);
      check("abort_acc_out", acc_out, 0);
      check("abort_nrst_high", acc_nrst, 1);
      samp[0] = 16'd5;
      run_frame(1, 0, 0, 17'd5);
      // ABORT while the result is pending
      samp[0] = 16'd9;
      start = 1'b1; cfg_len = 8'd1;
      tick();
      start = 1'b0; s_valid = 1'b1; s_data = samp[0];
      tick();
      s_valid = 1'b0; abort = 1'b1;
      #1;
      check("abort_res_m_valid", m_valid, 0);
      tick();
      abort = 1'b0;
      check("abort_res_clr", acc_nrst, 0);
      tick();
      check("abort_res_busy", busy, 0);
      check("abort_res_acc_out", acc_out, 0);
      // NRST mid-frame
      start = 1'b1; cfg_len = 8'd4;
      tick();
      start = 1'b0; s_valid = 1'b1; s_data = 16'h1234;
      tick();
      tick();
      nrst = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_s_ready", s_ready, 0);
      check("midrst_en2", acc_en2, 0);
      check("midrst_acc_nrst", acc_nrst, 0);
      check("midrst_m_data", m_data, 0);
      tick();
      nrst = 1'b1; s_valid = 1'b0;
      tick();
      fill(4, 16'd1, 16'd1);
      run_frame(4, 0, 0, 17'd10);
      // Randomized frames against the arithmetic reference
      for (int f = 0; f < 25; f++) begin
         int len;
         len = $urandom_range(0, 20);
         for (int i = 0; i < len; i++) samp[i] = 16'($urandom);
         run_frame(len, 30, $urandom_range(0, 3), ref_sum(len));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/acc_frame_ctrl.md
Name: acc_frame_ctrl

Overview:
- Frame sequencer for the 16-bit-in / 17-bit-out signed accumulator datapath.
- Accepts a START command with a frame length, then streams samples into the accumulator over a valid/ready handshake. It drives the accumulator's EN2/EN3 strobes and presents the frame sum on an output handshake.
- Clears the accumulator between frames by pulsing the accumulator's reset from a flop.
- Sits between the sample source/result sink and one accumulator instance.

Parameters:
- LEN_W, 8, width of frame-length field; max frame length 2^LEN_W-1.

Ports:
- CLK  in  1  system clock
- NRST  in  1  asynchronous active-low reset
- START  in  1  one-cycle frame start request; honoured only in IDLE
- CFG_LEN  in  LEN_W  frame length, sampled when START is honoured
- ABORT  in  1  abandon current frame; no result is produced
- S_VALID  in  1  sample valid
- S_DATA  in  16  signed sample
- S_READY  out  1  controller accepts a sample
- M_VALID  out  1  frame result valid
- M_DATA  out  17  signed frame sum
- M_READY  in  1  result sink accepts
- BUSY  out  1  high in any state other than IDLE
- ACC_IN  out  16  to accumulator IN; equals S_DATA (combinational)
- ACC_EN2  out  1  to accumulator EN2
- ACC_EN3  out  1  to accumulator EN3
- ACC_NRST  out  1  to accumulator NRST; equals NRST AND clr_n_q
- ACC_OUT  in  17  from accumulator OUT

Behaviour:
- Clock and reset: single clock CLK. Reset NRST is asynchronous, active-low.
- Reset values:
  - state=IDLE, count=0, len_q=0, clr_n_q=1.
  - S_READY=0, M_VALID=0, BUSY=0, ACC_EN2=0, ACC_EN3=0.
  - ACC_NRST=0 while NRST is low.
  - M_DATA=ACC_OUT, which is 0 under reset.
- States: IDLE, ACCUM, RESULT, CLEAR.
- IDLE:
  - START=1 with CFG_LEN>0 -> ACCUM; len_q<=CFG_LEN, count<=0.
  - START=1 with CFG_LEN=0 -> RESULT directly, reporting the cleared sum of 0.
- ACCUM:
  - S_READY=1.
  - On S_VALID&S_READY: ACC_EN2=1 and count++.
  - If count==len_q-1 on that transfer: ACC_EN3=1 in the same cycle and next state is RESULT. The accumulator OUT register updates at that edge.
  - ACC_EN2/ACC_EN3 are combinational from the handshake, so there are no idle cycles between back-to-back samples.
- RESULT:
  - M_VALID=1 and M_DATA=ACC_OUT.
  - Result becomes valid one cycle after the last sample transfer, or one cycle after START when CFG_LEN=0.
  - M_DATA is held stable until M_READY; on M_VALID&M_READY -> CLEAR.
- CLEAR:
  - clr_n_q<=0 on the entering edge, so ACC_NRST is low for exactly one full cycle. This asynchronously zeroes accumulator FF and OUT.
  - Next edge: clr_n_q<=1, state -> IDLE.
  - START is ignored in CLEAR; earliest accepted START is one cycle later.
- ABORT (state ACCUM or RESULT): has priority over any same-cycle handshake. No EN2/EN3 is issued, S_READY and M_VALID are forced to 0 that cycle, and the next state is CLEAR. ABORT in IDLE or CLEAR has no effect.
- START while BUSY: ignored, no queueing.
- Arithmetic: the sum is two's-complement over 17 bits and wraps silently. No overflow detection; frames longer than 2 samples of full-scale data may wrap.
- ACC_NRST is derived only from NRST and a flop, so it is glitch-free.
- NRST asserted mid-frame: everything returns to reset values immediately and the partial frame is lost.

Decomposition:
- Shared package:
  - state encoding enum (IDLE, ACCUM, RESULT, CLEAR)
  - ACC_IN_W=16, ACC_OUT_W=17 constants
- No sub-module. The FSM, counter and clear flop form one block. The accumulator itself is instantiated alongside at the next level up.

Test Plan:
- LEN=4, samples 1,2,3,4 back-to-back -> M_VALID one cycle after 4th transfer; M_DATA=17'd10; then ACC_NRST low exactly 1 cycle; ACC_OUT=0 afterwards.
- LEN=3, samples 0xFFFF x3 -> M_DATA=0x1FFFD (-3).
- LEN=3, samples 0x7FFF x3 -> M_DATA=0x17FFD (wrapped, no flag).
- LEN=2 with M_READY held low 5 cycles -> M_VALID and M_DATA stable; S_READY=0; a START pulse during the stall is ignored.
- LEN=5, ABORT after 2 transfers -> no M_VALID; one-cycle ACC_NRST pulse; next START with LEN=1, sample 5 -> M_DATA=5.
- START with CFG_LEN=0 -> M_VALID the next cycle, M_DATA=0. Separately, NRST asserted mid-frame -> all outputs at reset values the same cycle.
